// File: rtl/cspwm_nch.sv
// Carrier-phase-shifted PWM core for cascaded H-bridge phase legs.
// N_CELL symmetric triangle carriers, each re-aligned to its own phase
// offset on syn, compared against a shadow-buffered signed reference to
// give unipolar left/right leg gate commands with min/max pulse clamping.
// Optional build macro: CSPWM_DOUBLE_UPDATE_EN adds a shadow load at the
// carrier peak in addition to the valley and syn loads.
module cspwm_nch #(
  parameter int N_CELL = 3,
  parameter int CNT_W  = 16,
  parameter int REF_W  = 16
) (
  input  logic                      clk_20M,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      syn,
  input  logic [CNT_W-1:0]          period,
  input  logic [N_CELL*CNT_W-1:0]   phase_init,
  input  logic [N_CELL*REF_W-1:0]   target_vol,
  input  logic [CNT_W-1:0]          pw_min,
  input  logic [CNT_W-1:0]          pw_max,
  output logic [N_CELL*CNT_W-1:0]   angle,
  output logic [N_CELL-1:0]         angle_dir,
  output logic [N_CELL-1:0]         pwm_left,
  output logic [N_CELL-1:0]         pwm_right,
  output logic [N_CELL-1:0]         load_stb
);

  // Wide enough for +/-period and for a reference wider than the counter.
  localparam int XW = (REF_W > CNT_W + 2) ? REF_W : CNT_W + 2;

  logic run;
  logic signed [XW-1:0] per_s, pmin_s, pmax_s;

  // Carriers only run with a period of at least two clocks.
  assign run    = (period >= CNT_W'(2));
  assign per_s  = XW'(period);
  assign pmin_s = XW'(pw_min);
  assign pmax_s = XW'(pw_max);

  for (genvar i = 0; i < N_CELL; i++) begin : g_cell
    logic [CNT_W-1:0]        ang, ph;
    logic                    dir, valley, peak, load, pl, pr;
    logic signed [REF_W-1:0] shadow;
    logic signed [XW-1:0]    ang_s, ref_s, ref_c, cmp_l, cmp_r, eff_l, eff_r;

    assign ph     = phase_init[i*CNT_W +: CNT_W];
    assign valley = (ang == '0) && !dir;
`ifdef CSPWM_DOUBLE_UPDATE_EN
    assign peak   = (ang == period) && dir;
`else
    assign peak   = 1'b0;
`endif
    // syn coinciding with a valley still yields a single load/strobe.
    assign load   = syn || valley || peak;

    // Triangle carrier: one-clock peak and valley, syn re-phases, a
    // shrinking period snaps the carrier onto the new peak heading down.
    always_ff @(posedge clk_20M) begin
      if (reset || !run) begin
        ang <= '0;
        dir <= 1'b1;
      end else if (syn) begin
        ang <= (ph > period) ? period : ph;
        dir <= 1'b1;
      end else if (ang > period) begin
        ang <= period;
        dir <= 1'b0;
      end else if (dir) begin
        if (ang == period) begin
          ang <= ang - 1'b1;
          dir <= 1'b0;
        end else begin
          ang <= ang + 1'b1;
        end
      end else begin
        if (ang == '0) begin
          ang <= ang + 1'b1;
          dir <= 1'b1;
        end else begin
          ang <= ang - 1'b1;
        end
      end
    end

    // Shadow reference, only sampled at the update points.
    always_ff @(posedge clk_20M) begin
      if (reset)
        shadow <= '0;
      else if (load)
        shadow <= $signed(target_vol[i*REF_W +: REF_W]);
    end

    // Reference clamp, leg compare levels and pulse-width clamping.
    always_comb begin
      ang_s = XW'(ang);
      ref_s = XW'(shadow);
      if (ref_s > per_s)
        ref_c = per_s;
      else if (ref_s < -per_s)
        ref_c = -per_s;
      else
        ref_c = ref_s;
      cmp_l = (per_s + ref_c) >>> 1;
      cmp_r = (per_s - ref_c) >>> 1;
      if (cmp_l < pmin_s)
        eff_l = '0;
      else if (cmp_l > pmax_s)
        eff_l = per_s + XW'(1);
      else
        eff_l = cmp_l;
      if (cmp_r < pmin_s)
        eff_r = '0;
      else if (cmp_r > pmax_s)
        eff_r = per_s + XW'(1);
      else
        eff_r = cmp_r;
    end

    // Registered gate commands, one clock behind the carrier value.
    always_ff @(posedge clk_20M) begin
      if (reset) begin
        pl <= 1'b0;
        pr <= 1'b0;
      end else begin
        pl <= start && run && (ang_s < eff_l);
        pr <= start && run && (ang_s < eff_r);
      end
    end

    assign angle[i*CNT_W +: CNT_W] = ang;
    assign angle_dir[i]            = dir;
    assign pwm_left[i]             = pl;
    assign pwm_right[i]            = pr;
    assign load_stb[i]             = !reset && load;
  end

endmodule

// File: tb/tb_cspwm_nch.sv
// Bench for cspwm_nch: lockstep triangle-position reference model plus
// directed checks of phase, period, duty and clamp behaviour.
module tb_cspwm_nch;
  localparam int N  = 3;
  localparam int CW = 16;
  localparam int RW = 16;

  logic clk_20M = 1'b0;
  logic reset, start, syn;
  logic [CW-1:0]   period, pw_min, pw_max;
  logic [N*CW-1:0] phase_init;
  logic [N*RW-1:0] target_vol;
  logic [N*CW-1:0] angle;
  logic [N-1:0]    angle_dir, pwm_left, pwm_right, load_stb;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: position s along the 2P-clock triangle, s = 0 is the valley.
  int mS[N];
  bit mF[N];
  int mP;
  int mSh[N];
  bit mL[N], mR[N];

  always #5 clk_20M = ~clk_20M;

  cspwm_nch #(.N_CELL(N), .CNT_W(CW), .REF_W(RW)) dut (
    .clk_20M(clk_20M), .reset(reset), .start(start), .syn(syn),
    .period(period), .phase_init(phase_init), .target_vol(target_vol),
    .pw_min(pw_min), .pw_max(pw_max), .angle(angle), .angle_dir(angle_dir),
    .pwm_left(pwm_left), .pwm_right(pwm_right), .load_stb(load_stb)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_ang(int i);
    if (mP < 2) return 0;
    return (mS[i] <= mP) ? mS[i] : 2 * mP - mS[i];
  endfunction

  function automatic int m_dir(int i);
    if (mP < 2) return 1;
    return (mF[i] || (mS[i] >= 1 && mS[i] <= mP)) ? 1 : 0;
  endfunction

  function automatic int eff(int sh, int p, bit right);
    int r, c;
    r = sh;
    if (r > p) r = p;
    if (r < -p) r = -p;
    c = right ? (p - r) / 2 : (p + r) / 2;
    if (c < int'(pw_min)) return 0;
    if (c > int'(pw_max)) return p + 1;
    return c;
  endfunction

  function automatic int tv(int i);
    logic signed [RW-1:0] v;
    v = target_vol[i*RW +: RW];
    return int'(v);
  endfunction

  task automatic set_tv(input int v);
    for (int i = 0; i < N; i++) target_vol[i*RW +: RW] = v[RW-1:0];
  endtask

  // One clock: compare DUT against model, advance model, return after edge.
  task automatic step();
    int p, a, d, ld, ph;
    @(negedge clk_20M); #1;
    p = int'(period);
    for (int i = 0; i < N; i++) begin
      a = m_ang(i);
      d = m_dir(i);
      ld = (syn || (a == 0 && d == 0)) ? 1 : 0;
`ifdef CSPWM_DOUBLE_UPDATE_EN
      if (a == p && d == 1) ld = 1;
`endif
      if (reset) ld = 0;
      check("angle", int'(angle[i*CW +: CW]), a);
      check("dir", int'(angle_dir[i]), d);
      check("pwm_left", int'(pwm_left[i]), int'(mL[i]));
      check("pwm_right", int'(pwm_right[i]), int'(mR[i]));
      check("load_stb", int'(load_stb[i]), ld);
      if (reset) begin
        mS[i] = 0; mF[i] = 1; mSh[i] = 0; mL[i] = 0; mR[i] = 0;
      end else begin
        mL[i] = start && p >= 2 && a < eff(mSh[i], p, 0);
        mR[i] = start && p >= 2 && a < eff(mSh[i], p, 1);
        if (ld != 0) mSh[i] = tv(i);
        if (p < 2) begin
          mS[i] = 0; mF[i] = 1;
        end else if (syn) begin
          ph = int'(phase_init[i*CW +: CW]);
          mS[i] = (ph > p) ? p : ph;
          mF[i] = 1;
        end else begin
          mS[i] = (mS[i] + 1) % (2 * p);
          mF[i] = 0;
        end
      end
    end
    mP = p;
    @(posedge clk_20M); #1;
  endtask

  task automatic count_win(input int len, output int cl, output int cr, output int cs);
    cl = 0; cr = 0; cs = 0;
    for (int k = 0; k < len; k++) begin
      step();
      cl += int'(pwm_left[0]);
      cr += int'(pwm_right[0]);
      cs += int'(load_stb[0]);
    end
  endtask

  initial begin
    int n, cl, cr, cs, v;
    reset = 1; start = 0; syn = 0; period = 100;
    pw_min = 0; pw_max = 200; phase_init = '0; target_vol = '0;
    for (int i = 0; i < N; i++) begin
      mS[i] = 0; mF[i] = 1; mSh[i] = 0; mL[i] = 0; mR[i] = 0;
    end
    mP = 100;

    // Reset held two clocks.
    @(posedge clk_20M); #1;
    step();
    reset = 0;

    // Phase offsets 0/66/132(->100) and sync.
    phase_init[0*CW +: CW] = 16'd0;
    phase_init[1*CW +: CW] = 16'd66;
    phase_init[2*CW +: CW] = 16'd132;
    set_tv(50); start = 1; syn = 1;
    step();
    syn = 0;
    check("sync_a0", int'(angle[0*CW +: CW]), 0);
    check("sync_a1", int'(angle[1*CW +: CW]), 66);
    check("sync_a2", int'(angle[2*CW +: CW]), 100);
    n = 0;
    while (int'(angle[CW-1:0]) != 100 && n < 300) begin step(); n++; end
    check("peak_latency", n, 100);
    step(); n = 1;
    while (int'(angle[CW-1:0]) != 100 && n < 400) begin step(); n++; end
    check("carrier_period", n, 200);

    // Duty over one full carrier period, reference +50.
    count_win(200, cl, cr, cs);
    check("duty_left", cl, 149);
    check("duty_right", cr, 49);
`ifdef CSPWM_DOUBLE_UPDATE_EN
    check("loads_per_period", cs, 2);
`else
    check("loads_per_period", cs, 1);
`endif

    // Clamp: +96 with pw 5..95, then +300 saturating to +100.
    pw_min = 5; pw_max = 95; set_tv(96); syn = 1;
    step(); syn = 0; step(); step();
    count_win(200, cl, cr, cs);
    check("clamp96_left", cl, 200);
    check("clamp96_right", cr, 0);
    set_tv(300); syn = 1;
    step(); syn = 0; step(); step();
    count_win(200, cl, cr, cs);
    check("clamp300_left", cl, 200);
    check("clamp300_right", cr, 0);

    // Mid-ramp reference change waits for the next update point.
    pw_min = 0; pw_max = 200; set_tv(50); syn = 1;
    step(); syn = 0; step(); step(); step();
    set_tv(-50);
    n = 0;
    while (!load_stb[0] && n < 400) begin step(); n++; end
`ifdef CSPWM_DOUBLE_UPDATE_EN
    check("midramp_wait", n, 97);
`else
    check("midramp_wait", n, 197);
`endif
    for (int k = 0; k < 50; k++) step();

    // start low forces legs off while carriers keep running.
    start = 0;
    step();
    check("stop_left", int'(pwm_left), 0);
    check("stop_right", int'(pwm_right), 0);
    for (int k = 0; k < 20; k++) step();
    start = 1;

    // Randomized operation, period changes only with syn or reset.
    for (int k = 0; k < 1500; k++) begin
      syn = 0; reset = 0;
      if ($urandom_range(150) == 0) begin
        syn = 1;
        period = ($urandom_range(7) == 0) ? CW'($urandom_range(1)) : CW'($urandom_range(60, 2));
        for (int i = 0; i < N; i++) phase_init[i*CW +: CW] = CW'($urandom_range(80));
        pw_min = CW'($urandom_range(20));
        pw_max = CW'($urandom_range(70));
      end else if ($urandom_range(400) == 0) begin
        reset = 1;
      end
      if ($urandom_range(7) == 0) begin
        for (int i = 0; i < N; i++) begin
          v = int'($urandom_range(800)) - 400;
          target_vol[i*RW +: RW] = v[RW-1:0];
        end
      end
      if ($urandom_range(50) == 0) start = ~start;
      step();
    end

    // Reset mid-period.
    syn = 0; start = 1; period = 40; reset = 1;
    step();
    reset = 0;
    step();
    check("rst_mid_angle", int'(angle[CW-1:0]), 1);

    // Period shrunk below the current angle.
    period = 100;
    for (int i = 0; i < N; i++) phase_init[i*CW +: CW] = 16'd90;
    syn = 1;
    step();
    syn = 0; period = 50;
    @(posedge clk_20M); #1;
    for (int i = 0; i < N; i++) begin
      check("shrink_angle", int'(angle[i*CW +: CW]), 50);
      check("shrink_dir", int'(angle_dir[i]), 0);
    end
    @(posedge clk_20M); #1;
    check("shrink_next", int'(angle[CW-1:0]), 49);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
